// File: rtl/aabb_hit_pipe.sv
// aabb_hit_pipe: four-stage ray versus axis-aligned-box slab tester.
// Each transaction is one ray tested against NUM_BOX boxes. The result is
// reduced to one winner (closest hit, or lowest qualifying slot in any-hit
// mode), together with the normal of the face the ray enters through.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   in_valid/in_ready ray + boxes handshake
//   in_any_hit        1 = lowest qualifying slot wins, 0 = smallest hit t wins
//   ray_orig/invdir/dir  {z,y,x} fixed-point vectors (only the sign of dir is used)
//   ray_min_t/max_t   hit interval (a negative max_t means unbounded)
//   ray_pi            primitive the ray left; a box carrying it is excluded
//   box_min/max/pi    per-box bounds and primitive index (all-ones = empty slot)
//   out_valid/ready   result handshake
//   out_hit, out_pi, out_idx, out_t, out_norm_axis, out_norm_neg  winner
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. valid never depends on ready. Once raised, out_valid and the
// result fields hold steady until the transfer. in_ready is combinational
// from out_ready through the per-stage advance chain.
// Pipeline: S1 = deltas, S2 = slab t values, S3 = per-box interval,
// S4 = qualify, reduce and normal (S4 registers drive the outputs).
module aabb_hit_pipe #(
    parameter int W       = 32,
    parameter int FRAC    = 16,
    parameter int NUM_BOX = 4,
    parameter int PI_W    = 16
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic                                      in_any_hit,
    input  logic [3*W-1:0]                            ray_orig,
    input  logic [3*W-1:0]                            ray_invdir,
    input  logic [3*W-1:0]                            ray_dir,
    input  logic [W-1:0]                              ray_min_t,
    input  logic [W-1:0]                              ray_max_t,
    input  logic [PI_W-1:0]                           ray_pi,
    input  logic [NUM_BOX*3*W-1:0]                    box_min,
    input  logic [NUM_BOX*3*W-1:0]                    box_max,
    input  logic [NUM_BOX*PI_W-1:0]                   box_pi,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic                                      out_hit,
    output logic [PI_W-1:0]                           out_pi,
    output logic [((NUM_BOX > 1) ? $clog2(NUM_BOX) : 1)-1:0] out_idx,
    output logic [W-1:0]                              out_t,
    output logic [1:0]                                out_norm_axis,
    output logic                                      out_norm_neg
);
    localparam int IW = (NUM_BOX > 1) ? $clog2(NUM_BOX) : 1;
    localparam logic [PI_W-1:0] PI_NULL = '1;

    typedef logic signed [W-1:0] word_t;

    // Per-ray fields that travel alongside the arithmetic.
    typedef struct packed {
        logic                    any_hit;
        logic [W-1:0]            min_t;
        logic [W-1:0]            max_t;
        logic [PI_W-1:0]         ray_pi;
        logic [NUM_BOX*PI_W-1:0] box_pi;
        logic [2:0]              dpos;   // dir[a] > 0
        logic [2:0]              dneg;   // dir[a] < 0
    } side_t;

    function automatic word_t fxmul(input word_t a, input word_t b);
        logic signed [2*W-1:0] p;
        p = (2*W)'(a) * (2*W)'(b);
        p = p >>> FRAC;
        return p[W-1:0];
    endfunction

    function automatic word_t smin(input word_t a, input word_t b);
        return (a < b) ? a : b;
    endfunction

    function automatic word_t smax(input word_t a, input word_t b);
        return (a > b) ? a : b;
    endfunction

    logic  v1_q, v2_q, v3_q, v4_q;
    logic  adv1, adv2, adv3, adv4;
    side_t in_side, s1_side_q, s2_side_q, s3_side_q;
    word_t s1_inv_q [3];
    word_t s1_d0_q [NUM_BOX][3];
    word_t s1_d1_q [NUM_BOX][3];
    word_t s2_t0_q [NUM_BOX][3];
    word_t s2_t1_q [NUM_BOX][3];
    word_t s3_t0_q [NUM_BOX][3];
    word_t s3_t1_q [NUM_BOX][3];
    word_t s3_tmin_d [NUM_BOX];
    word_t s3_tmax_d [NUM_BOX];
    word_t s3_hit_d  [NUM_BOX];
    word_t s3_tmin_q [NUM_BOX];
    word_t s3_tmax_q [NUM_BOX];
    word_t s3_hit_q  [NUM_BOX];
    word_t s3_min_t, s3_max_t;

    logic            s4_qual, s4_found, s4_neg;
    logic [IW-1:0]   s4_idx;
    word_t           s4_t;
    logic [PI_W-1:0] s4_pi, s4_bpi;
    logic [1:0]      s4_axis;

    logic            out_valid_q, out_hit_q, out_neg_q;
    logic [PI_W-1:0] out_pi_q;
    logic [IW-1:0]   out_idx_q;
    logic [W-1:0]    out_t_q;
    logic [1:0]      out_axis_q;

    // A stage may load when it is empty or its contents move on this edge.
    always_comb begin
        adv4     = !v4_q || out_ready;
        adv3     = !v3_q || adv4;
        adv2     = !v2_q || adv3;
        adv1     = !v1_q || adv2;
        in_ready = adv1;
    end

    always_comb begin
        in_side         = '0;
        in_side.any_hit = in_any_hit;
        in_side.min_t   = ray_min_t;
        in_side.max_t   = ray_max_t;
        in_side.ray_pi  = ray_pi;
        in_side.box_pi  = box_pi;
        for (int a = 0; a < 3; a++) begin
            in_side.dpos[a] = $signed(ray_dir[a*W +: W]) > 0;
            in_side.dneg[a] = ray_dir[a*W + W - 1];
        end
    end

    // S3 interval: the extremes seed the running max/min so the loop
    // reduces exactly over the three axes.
    always_comb begin
        for (int b = 0; b < NUM_BOX; b++) begin
            s3_tmin_d[b] = {1'b1, {(W-1){1'b0}}};
            s3_tmax_d[b] = {1'b0, {(W-1){1'b1}}};
            for (int a = 0; a < 3; a++) begin
                s3_tmin_d[b] = smax(s3_tmin_d[b], smin(s2_t0_q[b][a], s2_t1_q[b][a]));
                s3_tmax_d[b] = smin(s3_tmax_d[b], smax(s2_t0_q[b][a], s2_t1_q[b][a]));
            end
            s3_hit_d[b] = (s3_tmin_d[b] > 0) ? s3_tmin_d[b] : s3_tmax_d[b];
        end
    end

    assign s3_min_t = s3_side_q.min_t;
    assign s3_max_t = s3_side_q.max_t;

    // S4 qualify/reduce. Strict '<' keeps the lowest slot on equal t.
    always_comb begin
        s4_qual  = 1'b0;
        s4_bpi   = PI_NULL;
        s4_found = 1'b0;
        s4_idx   = '0;
        s4_t     = '0;
        s4_pi    = PI_NULL;
        s4_axis  = 2'd3;
        s4_neg   = 1'b0;
        for (int b = 0; b < NUM_BOX; b++) begin
            s4_bpi  = s3_side_q.box_pi[b*PI_W +: PI_W];
            s4_qual = (s3_tmin_q[b] < s3_tmax_q[b]) && (s3_tmax_q[b] > 0) &&
                      ((s3_max_t < 0) || ((s3_min_t <= s3_hit_q[b]) && (s3_hit_q[b] <= s3_max_t))) &&
                      (s4_bpi != PI_NULL) && (s4_bpi != s3_side_q.ray_pi);
            if (s4_qual && (!s4_found || (!s3_side_q.any_hit && (s3_hit_q[b] < s4_t)))) begin
                s4_found = 1'b1;
                s4_idx   = IW'(b);
                s4_t     = s3_hit_q[b];
                s4_pi    = s4_bpi;
            end
        end
        // Walk z..x so the x axis has the final say on overlapping matches.
        for (int a = 2; a >= 0; a--) begin
            if (s4_found) begin
                if ((s4_t == s3_t0_q[s4_idx][a]) && s3_side_q.dpos[a]) begin
                    s4_axis = 2'(a);
                    s4_neg  = 1'b1;
                end else if ((s4_t == s3_t1_q[s4_idx][a]) && s3_side_q.dneg[a]) begin
                    s4_axis = 2'(a);
                    s4_neg  = 1'b0;
                end
            end
        end
    end

    // Datapath registers: no reset needed, qualified by the stage valids.
    always_ff @(posedge clk) begin
        if (adv1 && in_valid) begin
            s1_side_q <= in_side;
            for (int a = 0; a < 3; a++) begin
                s1_inv_q[a] <= ray_invdir[a*W +: W];
                for (int b = 0; b < NUM_BOX; b++) begin
                    s1_d0_q[b][a] <= box_min[(b*3+a)*W +: W] - ray_orig[a*W +: W];
                    s1_d1_q[b][a] <= box_max[(b*3+a)*W +: W] - ray_orig[a*W +: W];
                end
            end
        end
        if (adv2 && v1_q) begin
            s2_side_q <= s1_side_q;
            for (int b = 0; b < NUM_BOX; b++) begin
                for (int a = 0; a < 3; a++) begin
                    s2_t0_q[b][a] <= fxmul(s1_inv_q[a], s1_d0_q[b][a]);
                    s2_t1_q[b][a] <= fxmul(s1_inv_q[a], s1_d1_q[b][a]);
                end
            end
        end
        if (adv3 && v2_q) begin
            s3_side_q <= s2_side_q;
            s3_t0_q   <= s2_t0_q;
            s3_t1_q   <= s2_t1_q;
            s3_tmin_q <= s3_tmin_d;
            s3_tmax_q <= s3_tmax_d;
            s3_hit_q  <= s3_hit_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            v3_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_hit_q   <= 1'b0;
            out_pi_q    <= PI_NULL;
            out_idx_q   <= '0;
            out_t_q     <= '0;
            out_axis_q  <= 2'd3;
            out_neg_q   <= 1'b0;
        end else begin
            if (adv1) v1_q <= in_valid;
            if (adv2) v2_q <= v1_q;
            if (adv3) v3_q <= v2_q;
            if (adv4) begin
                out_valid_q <= v3_q;
                if (v3_q) begin
                    out_hit_q  <= s4_found;
                    out_pi_q   <= s4_pi;
                    out_idx_q  <= s4_idx;
                    out_t_q    <= s4_t;
                    out_axis_q <= s4_axis;
                    out_neg_q  <= s4_neg;
                end
            end
        end
    end

    assign v4_q          = out_valid_q;
    assign out_valid     = out_valid_q;
    assign out_hit       = out_hit_q;
    assign out_pi        = out_pi_q;
    assign out_idx       = out_idx_q;
    assign out_t         = out_t_q;
    assign out_norm_axis = out_axis_q;
    assign out_norm_neg  = out_neg_q;
endmodule

// File: doc/aabb_hit_pipe.md
Name: aabb_hit_pipe

Overview:
Pipelined, parametrised ray/AABB slab tester; successor to the combinational single-box hit logic in RayCore/Primitive.
Tests one ray against NUM_BOX boxes per transaction and reduces the results to the closest hit, with entry-face normal.
Valid/ready handshake with full backpressure; accepts one ray per cycle.
Sits between the BVH leaf fetch and the hit-record merge in RayCore.

Parameters:
W, 32, fixed-point word width (signed two's complement).
FRAC, 16, fractional bits; 1.0 = 1<<FRAC.
NUM_BOX, 4, boxes tested per ray (≥1).
PI_W, 16, primitive index width; all-ones = null index.

Ports:
clk  in  1  clock
rst  in  1  async active-high reset
in_valid  in  1  ray and boxes present
in_ready  out  1  stage 1 can accept
in_any_hit  in  1  mode: 1 = any-hit (lowest qualifying index wins), 0 = closest-hit
ray_orig  in  3*W  origin {z,y,x}
ray_invdir  in  3*W  1/dir per axis
ray_dir  in  3*W  direction (sign only used)
ray_min_t  in  W  interval min
ray_max_t  in  W  interval max; negative = infinite
ray_pi  in  PI_W  primitive the ray left (excluded)
box_min  in  NUM_BOX*3*W  per-box Min
box_max  in  NUM_BOX*3*W  per-box Max
box_pi  in  NUM_BOX*PI_W  per-box primitive index
out_valid  out  1  result present
out_ready  in  1  consumer accepts
out_hit  out  1  some box qualified
out_pi  out  PI_W  winning primitive; null when !out_hit
out_idx  out  clog2(NUM_BOX) (min 1)  winning slot
out_t  out  W  hit T
out_norm_axis  out  2  0=x,1=y,2=z,3=none
out_norm_neg  out  1  1 = normal −1, 0 = +1

Behaviour:
- Reset (async): all stage valids 0, out_valid 0, out_hit 0, out_pi all-ones, out_idx 0, out_t 0, out_norm_axis 3, out_norm_neg 0. in_ready 1 from the first cycle after reset deasserts.
- Four stages S1..S4; latency exactly 4 cycles from accept (in_valid&&in_ready) to out_valid with out_ready held high.
- Stall rule per stage k: advance = !valid_k || advance_{k+1}; advance_5 = out_ready. in_ready = advance_1 (combinational from out_ready through the chain; no bubbles at full throughput). Stalled stages hold data bit-exact.
- Output stable while out_valid && !out_ready; dropped only on the handshake.
- S1: d0 = Min−orig, d1 = Max−orig per axis/box, W-bit wrap.
- S2: t0 = (invdir*d0)>>>FRAC, t1 likewise. Full 2W signed product, arithmetic shift, truncate to W; no saturation.
- S3 per box: tmin = max over axes of min(t0,t1); tmax = min over axes of max(t0,t1). hit_t = (tmin>0) ? tmin : tmax.
- S4 qualify per box: tmin<tmax && tmax>0 && (ray_max_t<0 || (ray_min_t<=hit_t && hit_t<=ray_max_t)) && box_pi!=null && box_pi!=ray_pi. All compares signed.
- S4 reduce: closest mode = smallest hit_t, ties → lowest index; any-hit mode = lowest qualifying index. None qualify → out_hit 0, out_pi null, out_t 0, axis 3.
- Normal of winner, first match in order x,y,z: hit_t==t0[a] && dir[a]>0 → axis a, neg 1; hit_t==t1[a] && dir[a]<0 → axis a, neg 0. No match → axis 3.
- in_any_hit, ray_* fields and box_pi travel with the transaction through all stages.
- Reset mid-flight discards all in-flight rays; no output for them.

Test Plan:
- Box 0 Min(1,1,1) Max(2,2,2) pi 5, orig(0,1.5,1.5), dir(1,0,0) (invdir x=1, y/z=0x7FFFFFFF), ray_pi null, max_t −1, other slots null → 4 cycles later out_hit 1, out_pi 5, out_idx 0, out_t 1.0 (0x10000), axis 0, neg 1.
- Same ray, boxes pi 5 at x[3,4] and pi 7 at x[1,2] in slots 0/1, closest mode → out_pi 7, out_idx 1, out_t 1.0; any-hit mode → out_pi 5, out_idx 0, out_t 3.0.
- Origin inside box (0,0,0) in [−1,1]^3, dir +x → out_t 1.0, axis 3; ray_max_t 0.5 → out_hit 0, out_pi all-ones.
- box_pi == ray_pi == 5 on the only hitting box → out_hit 0; dir −x from orig(3,1.5,1.5) → out_t 1.0, axis 0, neg 0.
- 8 back-to-back rays, out_ready held low cycles 6–9 → in_ready low after the pipe fills, no loss or duplication, outputs in order, each held stable while stalled.
- rst pulsed with 3 rays in flight → out_valid 0 immediately, no stale results afterwards, in_ready 1 the cycle after release.
